// File: rtl/tcm_dec_trb_sched.sv
// Traceback job scheduler: queues regular and flush jobs in an in-order FIFO and
// issues them one at a time to the single traceback engine (req/ack, then done).
module tcm_dec_trb_sched #(
  parameter int pTRB_LENGTH = 64,
  parameter int pBIDX_W     = 2,
  parameter int pSTATE_W    = 6,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                             iclk,
  input  logic                             ireset,
  input  logic                             iclkena,
  input  logic                             istart,
  input  logic [pBIDX_W-1:0]               iraddr_bidx,
  input  logic [pSTATE_W-1:0]              istate,
  input  logic                             iflush,
  input  logic [pBIDX_W-1:0]               ifraddr_bidx,
  input  logic [$clog2(pTRB_LENGTH)-1:0]   ifraddr_addr,
  input  logic [$clog2(pTRB_LENGTH)-1:0]   ifsize_m1,
  input  logic [pSTATE_W-1:0]              ifstate,
  output logic                             otrb_req,
  output logic                             otrb_flush,
  output logic [pBIDX_W-1:0]               otrb_bidx,
  output logic [$clog2(pTRB_LENGTH)-1:0]   otrb_addr,
  output logic [$clog2(pTRB_LENGTH)-1:0]   otrb_size_m1,
  output logic [pSTATE_W-1:0]              otrb_state,
  input  logic                             itrb_ack,
  input  logic                             itrb_done,
  output logic                             oeof,
  output logic [$clog2(pFIFO_DEPTH):0]     olevel,
  output logic                             ooverflow
);

  localparam int AW = $clog2(pTRB_LENGTH);
  localparam int PW = $clog2(pFIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef struct packed {
    logic                flush;
    logic [pBIDX_W-1:0]  bidx;
    logic [AW-1:0]       addr;
    logic [AW-1:0]       size_m1;
    logic [pSTATE_W-1:0] state;
  } job_t;

  job_t          mem_q [pFIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    state_q, state_d;
  job_t          job_q, job_d;
  logic          req_q, req_d;
  logic          eof_q, eof_d;
  logic          ovf_q, ovf_d;

  logic          pop, push_reg, push_fl;
  logic [LW:0]   free_w;
  job_t          reg_job, fl_job, head;

  assign reg_job = '{flush: 1'b0, bidx: iraddr_bidx, addr: AW'(pTRB_LENGTH - 1),
                     size_m1: AW'(pTRB_LENGTH - 1), state: istate};
  assign fl_job  = '{flush: 1'b1, bidx: ifraddr_bidx, addr: ifraddr_addr,
                     size_m1: ifsize_m1, state: ifstate};
  assign head    = mem_q[rptr_q];

  // A pop on the ack cycle frees its slot for this cycle's pushes; the
  // regular entry claims free space before the flush entry.
  assign pop      = (state_q == ISSUE) && itrb_ack;
  assign free_w   = (LW+1)'(pFIFO_DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
  assign push_reg = istart && (free_w != '0);
  assign push_fl  = iflush && (free_w > (LW+1)'(istart));

  always_comb begin
    wptr_d  = wptr_q + PW'(push_reg) + PW'(push_fl);
    rptr_d  = rptr_q + PW'(pop);
    level_d = level_q + LW'(push_reg) + LW'(push_fl) - LW'(pop);
    ovf_d   = ovf_q | (istart & ~push_reg) | (iflush & ~push_fl);
    state_d = state_q;
    job_d   = job_q;
    req_d   = req_q;
    eof_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|level_q) begin
          state_d = ISSUE;
          job_d   = head;
          req_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (itrb_ack) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (itrb_done) begin
          eof_d = job_q.flush;
          if (|level_q) begin
            state_d = ISSUE;
            job_d   = head;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge iclk) begin
    if (ireset && iclkena) begin
      if (push_reg) mem_q[wptr_q] <= reg_job;
      if (push_fl)  mem_q[wptr_q + PW'(push_reg)] <= fl_job;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      state_q <= IDLE;
      job_q   <= '0;
      req_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (iclkena) begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      state_q <= state_d;
      job_q   <= job_d;
      req_q   <= req_d;
      eof_q   <= eof_d;
      ovf_q   <= ovf_d;
    end
  end

  assign otrb_req     = req_q;
  assign otrb_flush   = job_q.flush;
  assign otrb_bidx    = job_q.bidx;
  assign otrb_addr    = job_q.addr;
  assign otrb_size_m1 = job_q.size_m1;
  assign otrb_state   = job_q.state;
  assign oeof         = eof_q;
  assign olevel       = level_q;
  assign ooverflow    = ovf_q;

endmodule

// File: tb/tb_tcm_dec_trb_sched.sv
// Bench for tcm_dec_trb_sched: directed scenarios then random traffic, all
// checked each cycle against a queue-based job model.
module tb_tcm_dec_trb_sched;

  localparam int D = 4;

  typedef struct packed {
    logic       flush;
    logic [1:0] bidx;
    logic [5:0] addr;
    logic [5:0] size_m1;
    logic [5:0] state;
  } job_t;

  logic       iclk = 1'b0, ireset = 1'b0, iclkena = 1'b1;
  logic       istart = 1'b0, iflush = 1'b0;
  logic [1:0] iraddr_bidx = '0, ifraddr_bidx = '0;
  logic [5:0] istate = '0, ifraddr_addr = '0, ifsize_m1 = '0, ifstate = '0;
  logic       itrb_ack = 1'b0, itrb_done = 1'b0;
  logic       otrb_req, otrb_flush, oeof, ooverflow;
  logic [1:0] otrb_bidx;
  logic [5:0] otrb_addr, otrb_size_m1, otrb_state;
  logic [2:0] olevel;

  tcm_dec_trb_sched dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .istart(istart), .iraddr_bidx(iraddr_bidx), .istate(istate),
    .iflush(iflush), .ifraddr_bidx(ifraddr_bidx), .ifraddr_addr(ifraddr_addr),
    .ifsize_m1(ifsize_m1), .ifstate(ifstate),
    .otrb_req(otrb_req), .otrb_flush(otrb_flush), .otrb_bidx(otrb_bidx),
    .otrb_addr(otrb_addr), .otrb_size_m1(otrb_size_m1), .otrb_state(otrb_state),
    .itrb_ack(itrb_ack), .itrb_done(itrb_done),
    .oeof(oeof), .olevel(olevel), .ooverflow(ooverflow)
  );

  always #5 iclk = ~iclk;

  int ncmp = 0, nfail = 0;

  // Model: pending jobs, the job held by the engine interface, and which
  // phase of the handshake that job is in (0 none, 1 offered, 2 running).
  job_t q[$];
  job_t cur;
  int   phase;
  bit   m_eof, m_ovf;

  task automatic model_reset();
    q.delete();
    cur   = '0;
    phase = 0;
    m_eof = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    if (!ireset) begin
      model_reset();
    end else if (iclkena) begin
      m_eof = 0;
      if (phase == 0) begin
        if (q.size() > 0) begin cur = q[0]; phase = 1; end
      end else if (phase == 1) begin
        if (itrb_ack) begin void'(q.pop_front()); phase = 2; end
      end else begin
        if (itrb_done) begin
          m_eof = cur.flush;
          if (q.size() > 0) begin cur = q[0]; phase = 1; end
          else phase = 0;
        end
      end
      if (istart) begin
        if (q.size() < D) q.push_back('{1'b0, iraddr_bidx, 6'd63, 6'd63, istate});
        else m_ovf = 1;
      end
      if (iflush) begin
        if (q.size() < D) q.push_back('{1'b1, ifraddr_bidx, ifraddr_addr, ifsize_m1, ifstate});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("req", 32'(otrb_req), 32'(phase == 1));
    chk("eof", 32'(oeof), 32'(m_eof));
    chk("level", 32'(olevel), 32'(q.size()));
    chk("overflow", 32'(ooverflow), 32'(m_ovf));
    if (phase == 1) begin
      chk("flush", 32'(otrb_flush), 32'(cur.flush));
      chk("bidx", 32'(otrb_bidx), 32'(cur.bidx));
      chk("addr", 32'(otrb_addr), 32'(cur.addr));
      chk("size_m1", 32'(otrb_size_m1), 32'(cur.size_m1));
      chk("state", 32'(otrb_state), 32'(cur.state));
    end
  endtask

  // One clock: inputs already set, model follows the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge iclk);
    model_edge();
    #1;
    check_model();
    istart = 0; iflush = 0; itrb_ack = 0; itrb_done = 0; ireset = 1;
  endtask

  task automatic do_reset();
    ireset = 0; step(); ireset = 0; step();
    chk("rst_req", 32'(otrb_req), 0);
    chk("rst_flush", 32'(otrb_flush), 0);
    chk("rst_addr", 32'(otrb_addr), 0);
    chk("rst_eof", 32'(oeof), 0);
    chk("rst_level", 32'(olevel), 0);
    chk("rst_ovf", 32'(ooverflow), 0);
  endtask

  initial begin
    model_reset();
    @(negedge iclk);
    do_reset();

    // Single regular job
    istart = 1; iraddr_bidx = 2'd1; istate = 6'd5; step();
    chk("t1_level", 32'(olevel), 1);
    chk("t1_req_early", 32'(otrb_req), 0);
    step();
    chk("t1_req", 32'(otrb_req), 1);
    chk("t1_addr", 32'(otrb_addr), 63);
    chk("t1_size", 32'(otrb_size_m1), 63);
    chk("t1_flush", 32'(otrb_flush), 0);
    chk("t1_state", 32'(otrb_state), 5);
    itrb_ack = 1; step();
    chk("t1_req_ack", 32'(otrb_req), 0);
    step(); step();
    itrb_done = 1; step();
    chk("t1_eof", 32'(oeof), 0);
    step();
    chk("t1_idle", 32'(otrb_req), 0);

    // Frame end: regular + flush in the same cycle
    istart = 1; iraddr_bidx = 2'd0; istate = 6'd9;
    iflush = 1; ifraddr_bidx = 2'd2; ifraddr_addr = 6'd17; ifsize_m1 = 6'd17; ifstate = 6'd3;
    step();
    chk("t2_level", 32'(olevel), 2);
    step();
    chk("t2_first_flush", 32'(otrb_flush), 0);
    itrb_ack = 1; step();
    step();
    itrb_done = 1; step();
    chk("t2_b2b_req", 32'(otrb_req), 1);
    chk("t2_b2b_flush", 32'(otrb_flush), 1);
    chk("t2_b2b_addr", 32'(otrb_addr), 17);
    chk("t2_b2b_size", 32'(otrb_size_m1), 17);
    chk("t2_b2b_bidx", 32'(otrb_bidx), 2);
    chk("t2_eof_reg", 32'(oeof), 0);
    itrb_ack = 1; step();
    itrb_done = 1; step();
    chk("t2_eof", 32'(oeof), 1);
    step();
    chk("t2_eof_pulse", 32'(oeof), 0);

    // Overflow, then backpressure on the stalled head
    for (int i = 0; i < 5; i++) begin
      istart = 1; iraddr_bidx = 2'(i); istate = 6'(i + 20); step();
    end
    chk("t3_level", 32'(olevel), 4);
    chk("t3_ovf", 32'(ooverflow), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_state", 32'(otrb_state), 20);
      chk("t4_hold_req", 32'(otrb_req), 1);
    end
    chk("t3_ovf_sticky", 32'(ooverflow), 1);
    itrb_ack = 1; step();
    chk("t4_level_dec", 32'(olevel), 3);

    // Push and pop in the same cycle at full
    do_reset();
    for (int i = 0; i < 4; i++) begin istart = 1; istate = 6'(i); step(); end
    chk("t5_full", 32'(olevel), 4);
    itrb_ack = 1; istart = 1; istate = 6'd40; step();
    chk("t5_level", 32'(olevel), 4);
    chk("t5_no_ovf", 32'(ooverflow), 0);

    // Reset while running with 3 queued; a late done is ignored
    do_reset();
    for (int i = 0; i < 4; i++) begin istart = 1; step(); end
    itrb_ack = 1; step();
    chk("t6_level", 32'(olevel), 3);
    step();
    do_reset();
    itrb_done = 1; step();
    chk("t6_late_req", 32'(otrb_req), 0);
    chk("t6_late_eof", 32'(oeof), 0);
    chk("t6_late_level", 32'(olevel), 0);

    // Random traffic including clock-enable gaps and occasional reset
    for (int i = 0; i < 3000; i++) begin
      iclkena = ($urandom_range(0, 9) != 0);
      if (iclkena) begin
        istart = ($urandom_range(0, 4) == 0);
        iflush = ($urandom_range(0, 9) == 0);
      end
      iraddr_bidx  = 2'($urandom);
      istate       = 6'($urandom);
      ifraddr_bidx = 2'($urandom);
      ifraddr_addr = 6'($urandom);
      ifsize_m1    = 6'($urandom);
      ifstate      = 6'($urandom);
      itrb_ack     = $urandom_range(0, 1) == 1;
      itrb_done    = $urandom_range(0, 2) == 0;
      ireset       = ($urandom_range(0, 199) != 0);
      step();
    end
    iclkena = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
